v810_prefetch_queue: RTL and testbench

Parametrised instruction prefetch queue that replaces the single-register fetch path of the V810 pipeline front end. It issues word-aligned 32-bit fetches ahead of decode and buffers halfwords in a circular queue. It presents one complete 16- or 32-bit instruction per handshake to the IF/ID stage, removing the extra fetch cycle for 32-bit instructions that straddle a word boundary. A branch redirect flushes the queue and restarts fetch at the target.

---
 rtl/v810_pkg.sv | 21 ++
 rtl/v810_prefetch_queue_if.sv | 27 ++
 rtl/v810_hw_fifo.sv | 56 +++++
 rtl/v810_prefetch_queue.sv | 119 +++++++++++
 tb/tb_v810_prefetch_queue.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v810_pkg.sv
// Shared V810 definitions: halfword type, canonical NOP and the instruction
// length decode used by both the prefetch queue and the exec stage.
package v810_pkg;

  typedef logic [15:0] ins_hw_t;

  localparam ins_hw_t NOP_HW = 16'h9A00;

  // Opcode field bits [15:10] select the long (32-bit) encodings.
  function automatic logic is_ins32(input ins_hw_t hw);
    logic [5:0] op;
    op = hw[15:10];
    casez (op)
      6'b101???, 6'b110?0?, 6'b110?11, 6'b1110??, 6'b11110?, 6'b111111:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/v810_prefetch_queue_if.sv
// Prefetch queue bus bundle: memory fetch port, redirect and IF/ID handoff.
// master = queue side, slave = memory/decode environment.
interface v810_prefetch_queue_if;

  logic        if_req;
  logic [31:0] if_a;
  logic        if_ack;
  logic [31:0] if_d;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic        out_len32;

  modport master (
    output if_req, if_a, out_valid, out_ir, out_pc, out_len32,
    input  if_ack, if_d, flush, flush_pc, out_ready
  );

  modport slave (
    input  if_req, if_a, out_valid, out_ir, out_pc, out_len32,
    output if_ack, if_d, flush, flush_pc, out_ready
  );

endinterface

// File: rtl/v810_hw_fifo.sv
// Halfword circular buffer: writes 0-2 and pops 0-2 entries per cycle and
// exposes the two oldest entries. Caller guarantees no overflow or underflow.
module v810_hw_fifo
  import v810_pkg::*;
#(
  parameter int DEPTH_HW = 8
) (
  input  logic                      clk,
  input  logic                      ce,
  input  logic                      clr,
  input  logic [1:0]                push_n,
  input  ins_hw_t                   push_d0,
  input  ins_hw_t                   push_d1,
  input  logic [1:0]                pop_n,
  output ins_hw_t                   head0,
  output ins_hw_t                   head1,
  output logic [$clog2(DEPTH_HW):0] count
);

  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  ins_hw_t       mem [DEPTH_HW];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push_n);
        rd_ptr <= rd_ptr + PW'(pop_n);
        count  <= count + CW'(push_n) - CW'(pop_n);
      end
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count alone, which
  // keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (ce && !clr) begin
      if (push_n != 2'd0) mem[wr_ptr] <= push_d0;
      if (push_n == 2'd2) mem[wr_ptr + PTR_ONE] <= push_d1;
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PTR_ONE];

endmodule

// File: rtl/v810_prefetch_queue.sv
// V810 instruction prefetch queue: word fetches ahead of decode, one whole
// 16/32-bit instruction per handshake. Optional macro: V810_PFQ_STARVE_CNT_EN.
module v810_prefetch_queue
  import v810_pkg::*;
#(
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  ce,
  v810_prefetch_queue_if.master bus
`ifdef V810_PFQ_STARVE_CNT_EN
  ,
  output logic [31:0]           starve_cnt
`endif
);

  localparam int             CW      = $clog2(DEPTH_HW) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH_HW);
  localparam logic [31:0]    PC_BOOT = RESET_PC & ~32'h1;

  logic [31:0]   fetch_addr;
  logic [31:0]   head_pc;
  logic [31:0]   flush_target;
  logic          started;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          fetch_done;
  logic          pop_fire;
  logic          clr;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  ins_hw_t       push_d0;
  ins_hw_t       push_d1;
  ins_hw_t       head0;
  ins_hw_t       head1;
  logic          head_len32;

  // started keeps IF_REQ low in the first cycle after reset release.
  assign free         = DEPTH_C - count;
  assign bus.if_req   = started && !res && (free >= CW'(2));
  assign bus.if_a     = fetch_addr & ~32'h3;
  assign fetch_done   = bus.if_req && bus.if_ack;
  assign clr          = res || bus.flush;
  assign flush_target = bus.flush_pc & ~32'h1;

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    push_n  = 2'd0;
    push_d0 = bus.if_d[15:0];
    push_d1 = bus.if_d[31:16];
    if (fetch_done) begin
      if (fetch_addr[1]) begin
        // Misaligned redirect target: the low halfword precedes it.
        push_n  = 2'd1;
        push_d0 = bus.if_d[31:16];
      end else begin
        push_n  = 2'd2;
      end
    end
  end

  assign head_len32    = is_ins32(head0);
  assign bus.out_valid = (count != '0) && (!head_len32 || count >= CW'(2));
  assign pop_fire      = bus.out_valid && bus.out_ready;
  assign pop_n         = !pop_fire ? 2'd0 : (head_len32 ? 2'd2 : 2'd1);
  assign bus.out_len32 = bus.out_valid && head_len32;
  assign bus.out_pc    = head_pc;

  always_comb begin
    bus.out_ir = 32'h0;
    if (bus.out_valid) bus.out_ir = head_len32 ? {head1, head0} : {16'h0, head0};
  end

  v810_hw_fifo #(.DEPTH_HW(DEPTH_HW)) u_fifo (
    .clk     (clk),
    .ce      (ce),
    .clr     (clr),
    .push_n  (push_n),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .pop_n   (pop_n),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (ce) begin
      if (res) begin
        started    <= 1'b0;
        fetch_addr <= PC_BOOT;
        head_pc    <= PC_BOOT;
      end else if (bus.flush) begin
        started    <= 1'b1;
        fetch_addr <= flush_target;
        head_pc    <= flush_target;
      end else begin
        started <= 1'b1;
        if (fetch_done) fetch_addr <= fetch_addr + (fetch_addr[1] ? 32'd2 : 32'd4);
        if (pop_fire)   head_pc    <= head_pc + (head_len32 ? 32'd4 : 32'd2);
      end
    end
  end

`ifdef V810_PFQ_STARVE_CNT_EN
  always_ff @(posedge clk) begin
    if (ce) begin
      if (res) begin
        starve_cnt <= '0;
      end else if (bus.out_ready && !bus.out_valid && !bus.flush && starve_cnt != '1) begin
        starve_cnt <= starve_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_v810_prefetch_queue.sv
// Directed bench for v810_prefetch_queue: a scoreboard queue of expected
// instructions checked by a monitor on every accepted handshake.
module tb_v810_prefetch_queue;
  import v810_pkg::*;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        len32;
  } exp_t;

  logic clk = 1'b0;
  logic res;
  logic ce;
`ifdef V810_PFQ_STARVE_CNT_EN
  logic [31:0] starve_cnt;
`endif

  v810_prefetch_queue_if bus ();

  v810_prefetch_queue #(.DEPTH_HW(8), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .res (res),
    .ce  (ce),
    .bus (bus)
`ifdef V810_PFQ_STARVE_CNT_EN
    ,
    .starve_cnt (starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  int   ack_delay = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return {16'hC020, 16'h5555};
      32'h104: return {NOP_HW, 16'h1234};
      32'h040: return {16'h1111, 16'h1111};
      32'h300: return {NOP_HW, 16'h2222};
      32'h400: return {16'h3333, 16'h4444};
      default: return {NOP_HW, NOP_HW};
    endcase
  endfunction

  // Memory model: acks after ack_delay extra cycles of a stable request.
  logic        last_req = 1'b0;
  logic        last_ack = 1'b0;
  logic [31:0] last_a = '0;
  int          wcnt = 0;
  initial begin
    bus.if_ack = 1'b0;
    bus.if_d   = '0;
  end
  always @(posedge clk) begin
    #1;
    if (bus.if_req) begin
      if (!last_req || last_ack || bus.if_a != last_a) wcnt = 0;
      else wcnt = wcnt + 1;
      bus.if_ack = (wcnt >= ack_delay);
      bus.if_d   = bus.if_ack ? mem_word(bus.if_a) : 32'hDEAD_BEEF;
    end else begin
      bus.if_ack = 1'b0;
      wcnt = 0;
    end
    last_req = bus.if_req;
    last_a   = bus.if_a;
    last_ack = bus.if_ack;
  end

  // Monitor: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (!res && ce && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc", 64'(bus.out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ir", 64'(bus.out_ir), 64'(e.ir));
        check("sb_pc", 64'(bus.out_pc), 64'(e.pc));
        check("sb_len32", 64'(bus.out_len32), 64'(e.len32));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    res = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    res = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic push_exp(input logic [31:0] ir, input logic [31:0] pc, input logic len32);
    exp_t e;
    e.ir = ir;
    e.pc = pc;
    e.len32 = len32;
    exp_q.push_back(e);
  endtask

  initial begin
    int acks;
    logic [31:0] a_hold;
    ce = 1'b1;
    res = 1'b1;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.out_ready = 1'b0;

    // Reset state and first fetch from RESET_PC.
    tick();
    tick();
    @(negedge clk);
    check("rst_if_req", 64'(bus.if_req), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_ir", 64'(bus.out_ir), 64'd0);
    check("rst_out_len32", 64'(bus.out_len32), 64'd0);
    check("rst_out_pc", 64'(bus.out_pc), 64'd0);
    @(posedge clk);
    #2 res = 1'b0;
    @(negedge clk);
    check("c0_if_req", 64'(bus.if_req), 64'd0);
    tick();
    @(negedge clk);
    check("c1_if_req", 64'(bus.if_req), 64'd1);
    check("c1_if_a", 64'(bus.if_a), 64'h0);
    check("c1_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("c2_out_valid", 64'(bus.out_valid), 64'd1);
    check("c2_out_ir", 64'(bus.out_ir), 64'h0000_9A00);
    check("c2_out_pc", 64'(bus.out_pc), 64'h0);
    check("c2_out_len32", 64'(bus.out_len32), 64'd0);
    tick();
    push_exp(32'h0000_9A00, 32'h0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("pop_out_pc", 64'(bus.out_pc), 64'h2);

    // Consumer stalled: queue fills after four word fetches.
    do_reset();
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.if_req && bus.if_ack) acks++;
      tick();
    end
    check("full_acks", 64'(acks), 64'd4);
    check("full_if_req", 64'(bus.if_req), 64'd0);
    check("full_if_a", 64'(bus.if_a), 64'h10);
    a_hold = bus.if_a;
    tick();
    tick();
    check("full_if_a_hold", 64'(bus.if_a), 64'(a_hold));
    for (int i = 0; i < 8; i++) push_exp({16'h0, NOP_HW}, 32'(2 * i), 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.out_ready = 1'b0;
    check("drain_done", 64'(exp_q.size()), 64'd0);

    // Redirect to a misaligned 32-bit instruction; ready in the flush cycle is ignored.
    bus.flush = 1'b1;
    bus.flush_pc = 32'h103;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("f1_if_a", 64'(bus.if_a), 64'h100);
    check("f1_if_req", 64'(bus.if_req), 64'd1);
    check("f1_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("f2_if_a", 64'(bus.if_a), 64'h104);
    check("f2_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("f3_out_valid", 64'(bus.out_valid), 64'd1);
    check("f3_out_ir", 64'(bus.out_ir), 64'h1234_C020);
    check("f3_out_pc", 64'(bus.out_pc), 64'h102);
    check("f3_out_len32", 64'(bus.out_len32), 64'd1);
    tick();
    push_exp(32'h1234_C020, 32'h102, 1'b1);
    push_exp({16'h0, NOP_HW}, 32'h106, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;

    // Flush lands on the ack of a stale fetch; its data must never surface.
    ack_delay = 2;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h40;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    bus.flush = 1'b1;
    bus.flush_pc = 32'h300;
    @(negedge clk);
    check("stale_ack_cycle", 64'({bus.if_req, bus.if_ack}), 64'h3);
    tick();
    bus.flush = 1'b0;
    wait_valid("stale", 10);
    check("stale_out_pc", 64'(bus.out_pc), 64'h300);
    check("stale_out_ir", 64'(bus.out_ir), 64'h0000_2222);
    tick();
    push_exp(32'h0000_2222, 32'h300, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    // Clock enable low: a ready consumer must not advance the queue.
    ce = 1'b0;
    tick();
    tick();
    ce = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("ce_hold_pc", 64'(bus.out_pc), 64'h302);

    // Three-cycle memory wait: address held, halfwords arrive in order.
    ack_delay = 3;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h400;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wait_if_a", 64'(bus.if_a), 64'h400);
      check("wait_if_req", 64'(bus.if_req), 64'd1);
      check("wait_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    check("wait_out_valid_rise", 64'(bus.out_valid), 64'd1);
    tick();
    push_exp(32'h0000_4444, 32'h400, 1'b0);
    push_exp(32'h0000_3333, 32'h402, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;

`ifdef V810_PFQ_STARVE_CNT_EN
    // Starvation counter: ready consumer, empty queue, memory not answering.
    ack_delay = 20;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("starve_cnt", 64'(starve_cnt), 64'd5);
`endif

    tick();
    tick();
    check("sb_all_consumed", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
